// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned MULDIV_ITERS = XLEN;
  localparam int unsigned CNT_W        = $clog2(MULDIV_ITERS);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_e;

  typedef enum logic {
    STEP_MUL,
    STEP_DIV
  } step_mode_e;

  // Two's-complement magnitude when neg is set, passthrough otherwise.
  function automatic logic [XLEN-1:0] abs_if(input logic neg, input logic [XLEN-1:0] v);
    return neg ? XLEN'(-v) : v;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage handshake between the pipeline and the mul/div sequencer.
interface muldiv_sequencer_if;
  import muldiv_pkg::*;

  logic            start;
  logic [2:0]      Funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            kill;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, Funct3, op_a, op_b, kill,
    input  busy, stall, done, result
  );

  modport slave (
    input  start, Funct3, op_a, op_b, kill,
    output busy, stall, done, result
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration: shift-add multiply or restoring divide on a 2*XLEN accumulator.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  step_mode_e        mode,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] rem_new;
  logic            ge;

  // Multiply: {hi, lo} with multiplier in lo. Divide: {remainder, dividend/quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    ge       = (rem_sh >= {1'b0, operand});
    rem_new  = ge ? XLEN'(rem_sh - {1'b0, operand}) : rem_sh[XLEN-1:0];
    acc_next = {mul_sum, acc[XLEN-1:1]};
    if (mode == STEP_DIV) begin
      acc_next = {rem_new, acc[XLEN-2:0], ge};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, stalls the pipeline while busy.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input logic              clk,
  input logic              reset,
  muldiv_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MULDIV_ITERS - 1);

  state_e            state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2*XLEN-1:0] acc_q, acc_d, acc_step;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic              busy_q, busy_d, done_q, done_d;

  logic              is_div, is_rem, signed_a, signed_b;
  logic              div_zero, div_ovf, special, neg_res;
  logic [XLEN-1:0]   a_mag, b_mag, special_res, div_sel, fix_res;
  logic [2*XLEN-1:0] prod;
  step_mode_e        step_mode;

  // Operation decode, special cases and final sign/word selection.
  always_comb begin
    is_div      = f3_q[2];
    is_rem      = f3_q[2] & f3_q[1];
    signed_a    = (f3_q == F3_MULH) || (f3_q == F3_MULHSU) || (f3_q == F3_DIV) || (f3_q == F3_REM);
    signed_b    = (f3_q == F3_MULH) || (f3_q == F3_DIV) || (f3_q == F3_REM);
    a_mag       = abs_if(signed_a && a_q[XLEN-1], a_q);
    b_mag       = abs_if(signed_b && b_q[XLEN-1], b_q);
    div_zero    = is_div && (b_q == '0);
    div_ovf     = is_div && signed_b && (a_q == INT_MIN) && (b_q == '1);
    special     = div_zero || div_ovf;
    special_res = div_zero ? (is_rem ? a_q : '1) : (is_rem ? '0 : a_q);
    neg_res     = is_rem ? sign_a_q : (sign_a_q ^ sign_b_q);
    prod        = neg_res ? (2*XLEN)'(-acc_q) : acc_q;
    div_sel     = is_rem ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    if (is_div) begin
      fix_res = neg_res ? XLEN'(-div_sel) : div_sel;
    end else begin
      fix_res = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
    step_mode   = is_div ? STEP_DIV : STEP_MUL;
  end

  muldiv_step u_step (
    .acc      (acc_q),
    .operand  (is_div ? b_q : a_q),
    .mode     (step_mode),
    .acc_next (acc_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state; kill aborts any in-flight operation.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start && !bus.kill) state_d = S_PREP;
      S_PREP:  state_d = special ? S_DONE : S_ITER;
      S_ITER:  if (cnt_q == LAST_CNT) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.kill && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  // Datapath and output updates; result only moves on a surviving completion.
  always_comb begin
    f3_d     = f3_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (state_d == S_PREP) begin
          f3_d = bus.Funct3;
          a_d  = bus.op_a;
          b_d  = bus.op_b;
        end
      end
      S_PREP: begin
        sign_a_d = signed_a && a_q[XLEN-1];
        sign_b_d = signed_b && b_q[XLEN-1];
        a_d      = a_mag;
        b_d      = b_mag;
        acc_d    = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
        cnt_d    = '0;
        if (state_d == S_DONE) result_d = special_res;
      end
      S_ITER: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
      end
      S_FIX: begin
        if (state_d == S_DONE) result_d = fix_res;
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f3_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      f3_q     <= f3_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.stall  = (busy_q && !done_q) || ((state_q == S_IDLE) && bus.start && !bus.kill);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: values, latency, stall/busy, kill and reset behaviour.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic clk;
  logic reset;

  muldiv_sequencer_if bus_if ();

  muldiv_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; start is sampled at the next rising edge (cycle N).
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int   cyc       = 0;
    int   stall_cyc = 0;
    bit   seen      = 1'b0;
    logic [1:0] bs_at_done = 2'b00;
    bus_if.start  = 1'b1;
    bus_if.kill   = 1'b0;
    bus_if.Funct3 = f3;
    bus_if.op_a   = a;
    bus_if.op_b   = b;
    #1;
    chk({tag, ".stall_req"}, 32'(bus_if.stall), 32'd1);
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus_if.done) begin
        seen       = 1'b1;
        bs_at_done = {bus_if.busy, bus_if.stall};
      end else if (bus_if.busy && bus_if.stall) begin
        stall_cyc++;
      end
      // Operand churn after capture must not affect the result.
      bus_if.start  = 1'b0;
      bus_if.Funct3 = ~f3;
      bus_if.op_a   = ~a;
      bus_if.op_b   = ~b;
    end
    chk({tag, ".done_seen"}, 32'(seen), 32'd1);
    chk({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, ".stall_cycles"}, 32'(stall_cyc), 32'(exp_lat - 1));
    chk({tag, ".busy_stall_at_done"}, 32'(bs_at_done), 32'd2);
    chk({tag, ".result"}, bus_if.result, exp_res);
    @(negedge clk);
    chk({tag, ".idle_after"}, 32'({bus_if.busy, bus_if.done, bus_if.stall}), 32'd0);
    chk({tag, ".result_hold"}, bus_if.result, exp_res);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit saw_done;
    reset         = 1'b1;
    bus_if.start  = 1'b0;
    bus_if.kill   = 1'b0;
    bus_if.Funct3 = 3'b000;
    bus_if.op_a   = '0;
    bus_if.op_b   = '0;
    repeat (2) @(negedge clk);
    chk("reset.outputs", 32'({bus_if.busy, bus_if.done, bus_if.stall}), 32'd0);
    chk("reset.result", bus_if.result, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    run_op("mul",     F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 35);
    run_op("mulh",    F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 35);
    run_op("mulhu",   F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 35);
    run_op("mulhsu",  F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 35);
    run_op("divu",    F3_DIVU,   32'd100,        32'd7,         32'd14,        35);
    run_op("remu",    F3_REMU,   32'd100,        32'd7,         32'd2,         35);
    run_op("div_neg", F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 35);
    run_op("rem_neg", F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 35);
    run_op("div_by0", F3_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 2);
    run_op("remu_by0",F3_REMU,   32'd5,          32'd0,         32'd5,         2);
    run_op("rem_ovf", F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         2);
    run_op("divu_big",F3_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         35);
    run_op("div_ovf", F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2);

    // Kill in cycle N+10 of a DIVU; new start in N+11.
    saw_done      = 1'b0;
    bus_if.start  = 1'b1;
    bus_if.Funct3 = F3_DIVU;
    bus_if.op_a   = 32'd1000;
    bus_if.op_b   = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus_if.start = 1'b0;
      if (bus_if.done) saw_done = 1'b1;
    end
    bus_if.kill = 1'b1;
    @(negedge clk);
    chk("kill.busy", 32'(bus_if.busy), 32'd0);
    chk("kill.no_done", 32'(saw_done | bus_if.done), 32'd0);
    chk("kill.result_kept", bus_if.result, 32'h8000_0000);
    bus_if.kill = 1'b0;
    run_op("kill_restart", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35);

    // start and kill together in IDLE: nothing captured.
    saw_done      = 1'b0;
    bus_if.start  = 1'b1;
    bus_if.kill   = 1'b1;
    bus_if.Funct3 = F3_MUL;
    bus_if.op_a   = 32'd3;
    bus_if.op_b   = 32'd3;
    #1;
    chk("startkill.stall", 32'(bus_if.stall), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus_if.busy || bus_if.done) saw_done = 1'b1;
    end
    chk("startkill.idle", 32'(saw_done), 32'd0);
    chk("startkill.result", bus_if.result, 32'hFFFF_FFFE);
    bus_if.start = 1'b0;
    bus_if.kill  = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of ITER, released between edges.
    bus_if.start  = 1'b1;
    bus_if.Funct3 = F3_MUL;
    bus_if.op_a   = 32'd9;
    bus_if.op_b   = 32'd9;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus_if.start = 1'b0;
    end
    chk("prereset.busy", 32'(bus_if.busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("areset.outputs", 32'({bus_if.busy, bus_if.done, bus_if.stall}), 32'd0);
    chk("areset.result", bus_if.result, 32'h0);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("postreset.idle", 32'({bus_if.busy, bus_if.done}), 32'd0);
    run_op("mul_after_reset", F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
